// File: rtl/tpu_pkg.sv
// Shared types and helpers for the TPU tile sequencer and its sibling controllers.
//   ADDR_W         : width of one memory row address
//   TILE_CNT_W     : width of the tile counter / tile count field
//   MAX_LANES      : widest replicated address bus replicate_addr can build
//   seq_state_e    : sequencer FSM state encoding
//   seq_cmd_t      : one tile-operation command as offered on the command port
//   replicate_addr : copies one row address into every lane of a bus
package tpu_pkg;

  localparam int unsigned ADDR_W     = 8;
  localparam int unsigned TILE_CNT_W = 4;
  localparam int unsigned MAX_LANES  = 64;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_FILL         = 3'd1,
    ST_FILL_WAIT    = 3'd2,
    ST_DRAIN        = 3'd3,
    ST_COMPUTE      = 3'd4,
    ST_COMPUTE_WAIT = 3'd5,
    ST_NEXT         = 3'd6,
    ST_ERROR        = 3'd7
  } seq_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0]     weight_base;
    logic [ADDR_W-1:0]     input_base;
    logic [ADDR_W-1:0]     output_base;
    logic [TILE_CNT_W-1:0] num_tiles;
    logic                  reuse_weights;
  } seq_cmd_t;

  // Callers size-cast the result down to their own lane count (<= MAX_LANES).
  function automatic logic [MAX_LANES*ADDR_W-1:0] replicate_addr(input logic [ADDR_W-1:0] addr);
    return {MAX_LANES{addr}};
  endfunction

endpackage

// File: rtl/seq_timeout_counter.sv
// Wait-state watchdog shared by the sequencing controllers.
//   clk, reset : clock, asynchronous active-low reset
//   clear      : restart the count at zero (takes priority over enable)
//   enable     : count this cycle
//   expired    : the count currently held equals TIMEOUT_CYCLES-1
module seq_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Saturate at the limit so a caller that lingers never sees a wrapped count.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != LIMIT)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // expired is registered alongside the count it describes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      expired <= 1'b0;
    end else begin
      count_q <= count_d;
      expired <= (count_d == LIMIT);
    end
  end

endmodule

// File: rtl/tpu_sequencer.sv
// Command-driven tile sequencer for the systolic-array top level: weight load into
// the FIFOs, FIFO drain into the array, compute, then output writeback, per tile.
//   clk, reset                    : clock, asynchronous active-low reset
//   cmd_valid / cmd_ready         : command handshake (ready only in IDLE)
//   cmd_*                         : first-tile bases, tile count minus 1, weight reuse
//   mem_to_fifo_done,
//   fifo_to_arr_done, output_done : level completion indications from top
//   fill_fifo, drain_fifo, active : mutually exclusive strobes to top
//   *_addr_base                   : current row bases replicated per lane
//   busy, done, err, tile_idx     : status (done is a pulse, err is sticky)
module tpu_sequencer
  import tpu_pkg::*;
#(
  parameter int unsigned WIDTH_HEIGHT   = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic [ADDR_W-1:0]              cmd_weight_base,
  input  logic [ADDR_W-1:0]              cmd_input_base,
  input  logic [ADDR_W-1:0]              cmd_output_base,
  input  logic [TILE_CNT_W-1:0]          cmd_num_tiles,
  input  logic                           cmd_reuse_weights,
  input  logic                           mem_to_fifo_done,
  input  logic                           fifo_to_arr_done,
  input  logic                           output_done,
  output logic                           fill_fifo,
  output logic                           drain_fifo,
  output logic                           active,
  output logic [WIDTH_HEIGHT*ADDR_W-1:0] weightMem_rd_addr_base,
  output logic [WIDTH_HEIGHT*ADDR_W-1:0] inputMem_rd_addr_base,
  output logic [WIDTH_HEIGHT*ADDR_W-1:0] outputMem_wr_addr_base,
  output logic                           busy,
  output logic                           done,
  output logic                           err,
  output logic [TILE_CNT_W-1:0]          tile_idx
);

  localparam int unsigned BUS_W = WIDTH_HEIGHT * ADDR_W;
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(WIDTH_HEIGHT);

  seq_cmd_t   cmd;
  seq_state_e state_q;
  seq_state_e state_d;

  logic [ADDR_W-1:0]     weight_addr_q, weight_addr_d;
  logic [ADDR_W-1:0]     input_addr_q, input_addr_d;
  logic [ADDR_W-1:0]     output_addr_q, output_addr_d;
  logic [TILE_CNT_W-1:0] num_tiles_q, num_tiles_d;
  logic [TILE_CNT_W-1:0] tile_idx_d;

  logic fill_d, drain_d, active_d, ready_d, busy_d, done_d, err_d;
  logic accept, last_tile, in_wait, timer_clear, timer_expired;

  assign cmd = '{
    weight_base:   cmd_weight_base,
    input_base:    cmd_input_base,
    output_base:   cmd_output_base,
    num_tiles:     cmd_num_tiles,
    reuse_weights: cmd_reuse_weights
  };

  // cmd_ready is a registered decode of IDLE, so it doubles as the IDLE qualifier.
  assign accept    = cmd_valid && cmd_ready;
  assign last_tile = (tile_idx == num_tiles_q);
  assign in_wait   = (state_q == ST_FILL_WAIT) || (state_q == ST_DRAIN) ||
                     (state_q == ST_COMPUTE_WAIT);
  // Every state change restarts the watchdog, which covers each wait-state entry.
  assign timer_clear = (state_d != state_q);

  seq_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (timer_clear),
    .enable (in_wait),
    .expired(timer_expired)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus next values of every registered output and datapath register.
  always_comb begin
    state_d       = state_q;
    weight_addr_d = weight_addr_q;
    input_addr_d  = input_addr_q;
    output_addr_d = output_addr_q;
    num_tiles_d   = num_tiles_q;
    tile_idx_d    = tile_idx;
    err_d         = err;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          // Weight reuse only ever skips the load of the first tile.
          state_d       = cmd.reuse_weights ? ST_COMPUTE : ST_FILL;
          weight_addr_d = cmd.weight_base;
          input_addr_d  = cmd.input_base;
          output_addr_d = cmd.output_base;
          num_tiles_d   = cmd.num_tiles;
          tile_idx_d    = '0;
          err_d         = 1'b0;
        end
      end
      ST_FILL: state_d = ST_FILL_WAIT;
      // A done arriving together with expiry wins over the timeout.
      ST_FILL_WAIT: begin
        if (mem_to_fifo_done)   state_d = ST_DRAIN;
        else if (timer_expired) state_d = ST_ERROR;
      end
      ST_DRAIN: begin
        if (fifo_to_arr_done)   state_d = ST_COMPUTE;
        else if (timer_expired) state_d = ST_ERROR;
      end
      ST_COMPUTE: state_d = ST_COMPUTE_WAIT;
      ST_COMPUTE_WAIT: begin
        if (output_done)        state_d = ST_NEXT;
        else if (timer_expired) state_d = ST_ERROR;
      end
      ST_NEXT: begin
        if (last_tile) begin
          state_d = ST_IDLE;
        end else begin
          state_d       = ST_FILL;
          tile_idx_d    = tile_idx + TILE_CNT_W'(1);
          weight_addr_d = weight_addr_q + ADDR_STEP;
          input_addr_d  = input_addr_q + ADDR_STEP;
          output_addr_d = output_addr_q + ADDR_STEP;
        end
      end
      ST_ERROR: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    if (state_d == ST_ERROR) begin
      err_d = 1'b1;
    end

    // Strobes follow the registered state, never the done inputs directly.
    fill_d   = (state_d == ST_FILL);
    drain_d  = (state_d == ST_DRAIN);
    active_d = (state_d == ST_COMPUTE);
    ready_d  = (state_d == ST_IDLE);
    busy_d   = (state_d != ST_IDLE);
    done_d   = (state_d == ST_NEXT) && (state_q == ST_COMPUTE_WAIT) && last_tile;
  end

  // Output and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fill_fifo     <= 1'b0;
      drain_fifo    <= 1'b0;
      active        <= 1'b0;
      cmd_ready     <= 1'b1;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      tile_idx      <= '0;
      num_tiles_q   <= '0;
      weight_addr_q <= '0;
      input_addr_q  <= '0;
      output_addr_q <= '0;
    end else begin
      fill_fifo     <= fill_d;
      drain_fifo    <= drain_d;
      active        <= active_d;
      cmd_ready     <= ready_d;
      busy          <= busy_d;
      done          <= done_d;
      err           <= err_d;
      tile_idx      <= tile_idx_d;
      num_tiles_q   <= num_tiles_d;
      weight_addr_q <= weight_addr_d;
      input_addr_q  <= input_addr_d;
      output_addr_q <= output_addr_d;
    end
  end

  assign weightMem_rd_addr_base = BUS_W'(replicate_addr(weight_addr_q));
  assign inputMem_rd_addr_base  = BUS_W'(replicate_addr(input_addr_q));
  assign outputMem_wr_addr_base = BUS_W'(replicate_addr(output_addr_q));

endmodule

// File: tb/tb_tpu_sequencer.sv
// Directed bench for tpu_sequencer. A small model of top answers each strobe with
// its done input, presented so it is sampled at the 5th rising edge after the
// strobe cycle begins; every cycle is logged as a strobe string for ordering checks.
module tb_tpu_sequencer;

  localparam int unsigned WH = 16;
  localparam int unsigned TO = 16;
  localparam int unsigned BW = WH * 8;

  logic          clk;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [7:0]    cmd_weight_base;
  logic [7:0]    cmd_input_base;
  logic [7:0]    cmd_output_base;
  logic [3:0]    cmd_num_tiles;
  logic          cmd_reuse_weights;
  logic          mem_to_fifo_done;
  logic          fifo_to_arr_done;
  logic          output_done;
  logic          fill_fifo;
  logic          drain_fifo;
  logic          active;
  logic [BW-1:0] w_bus;
  logic [BW-1:0] i_bus;
  logic [BW-1:0] o_bus;
  logic          busy;
  logic          done;
  logic          err;
  logic [3:0]    tile_idx;

  tpu_sequencer #(
    .WIDTH_HEIGHT  (WH),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .cmd_valid             (cmd_valid),
    .cmd_ready             (cmd_ready),
    .cmd_weight_base       (cmd_weight_base),
    .cmd_input_base        (cmd_input_base),
    .cmd_output_base       (cmd_output_base),
    .cmd_num_tiles         (cmd_num_tiles),
    .cmd_reuse_weights     (cmd_reuse_weights),
    .mem_to_fifo_done      (mem_to_fifo_done),
    .fifo_to_arr_done      (fifo_to_arr_done),
    .output_done           (output_done),
    .fill_fifo             (fill_fifo),
    .drain_fifo            (drain_fifo),
    .active                (active),
    .weightMem_rd_addr_base(w_bus),
    .inputMem_rd_addr_base (i_bus),
    .outputMem_wr_addr_base(o_bus),
    .busy                  (busy),
    .done                  (done),
    .err                   (err),
    .tile_idx              (tile_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  string log;
  int    cyc = 0;
  int    start_cyc;
  int    n_done;
  int    done_cyc;
  int    excl;
  int    fill_cnt;
  int    drain_cnt;
  int    comp_cnt;
  bit    drain_seen;
  bit    out_en;
  logic [7:0] act_w[$];
  logic [7:0] act_i[$];
  logic [7:0] act_o[$];
  logic [3:0] act_t[$];

  function automatic logic [BW-1:0] rep8(input logic [7:0] x);
    return {WH{x}};
  endfunction

  task automatic chkn(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkv(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chks(input string tag, input string obs, input string exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s observed=%s expected=%s", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    log        = "";
    n_done     = 0;
    done_cyc   = -1;
    excl       = 0;
    fill_cnt   = 0;
    drain_cnt  = 0;
    comp_cnt   = 0;
    drain_seen = 1'b0;
    act_w.delete();
    act_i.delete();
    act_o.delete();
    act_t.delete();
  endtask

  // Advance one cycle, observe outputs mid-cycle, then drive the top model.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    mem_to_fifo_done = 1'b0;
    fifo_to_arr_done = 1'b0;
    output_done      = 1'b0;
    if (fill_fifo)  log = {log, "F"};
    if (drain_fifo) log = {log, "D"};
    if (active) begin
      log = {log, "A"};
      chkv("w_bus_replicated", w_bus, rep8(w_bus[7:0]));
      chkv("i_bus_replicated", i_bus, rep8(i_bus[7:0]));
      chkv("o_bus_replicated", o_bus, rep8(o_bus[7:0]));
      act_w.push_back(w_bus[7:0]);
      act_i.push_back(i_bus[7:0]);
      act_o.push_back(o_bus[7:0]);
      act_t.push_back(tile_idx);
    end
    if (done) begin
      log = {log, "P"};
      n_done++;
      done_cyc = cyc;
    end
    if ((int'(fill_fifo) + int'(drain_fifo) + int'(active)) > 1) excl++;

    if (fill_fifo) fill_cnt = 4;
    else if (fill_cnt > 0) begin
      fill_cnt--;
      if (fill_cnt == 0) mem_to_fifo_done = 1'b1;
    end
    if (drain_fifo && !drain_seen) begin
      drain_seen = 1'b1;
      drain_cnt  = 4;
    end else if (drain_cnt > 0) begin
      drain_cnt--;
      if (drain_cnt == 0) fifo_to_arr_done = 1'b1;
    end
    if (!drain_fifo) drain_seen = 1'b0;
    if (active) comp_cnt = 4;
    else if (comp_cnt > 0) begin
      comp_cnt--;
      if (comp_cnt == 0 && out_en) output_done = 1'b1;
    end
  endtask

  task automatic issue(input logic [7:0] w, input logic [7:0] i, input logic [7:0] o,
                       input logic [3:0] n, input logic r);
    cmd_weight_base   = w;
    cmd_input_base    = i;
    cmd_output_base   = o;
    cmd_num_tiles     = n;
    cmd_reuse_weights = r;
    cmd_valid         = 1'b1;
    step();
    cmd_valid = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic run_until_idle(input int budget);
    int k;
    k = 0;
    do begin
      step();
      k++;
    end while (busy && k < budget);
    chkn("idle_within_budget", 32'(busy), 32'd0);
  endtask

  initial begin
    reset             = 1'b1;
    cmd_valid         = 1'b0;
    cmd_weight_base   = 8'h00;
    cmd_input_base    = 8'h00;
    cmd_output_base   = 8'h00;
    cmd_num_tiles     = 4'd0;
    cmd_reuse_weights = 1'b0;
    mem_to_fifo_done  = 1'b0;
    fifo_to_arr_done  = 1'b0;
    output_done       = 1'b0;
    out_en            = 1'b1;
    clear_log();
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);

    // Reset values
    chkn("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chkn("rst_strobes", 32'({fill_fifo, drain_fifo, active}), 32'd0);
    chkn("rst_status", 32'({busy, done, err}), 32'd0);
    chkn("rst_tile_idx", 32'(tile_idx), 32'd0);
    chkv("rst_w_bus", w_bus, '0);
    chkv("rst_o_bus", o_bus, '0);
    reset = 1'b1;
    @(negedge clk);

    // Single tile at base 0
    clear_log();
    issue(8'h00, 8'h00, 8'h00, 4'd0, 1'b0);
    run_until_idle(100);
    chks("single_order", log, "FDDDDDAP");
    chkn("single_done_at", 32'(done_cyc - start_cyc), 32'd15);
    chkn("single_w_base", 32'(act_w[0]), 32'h00);
    chkn("single_ready", 32'(cmd_ready), 32'd1);
    chkn("single_excl", 32'(excl), 32'd0);

    // Three tiles from 0x20
    clear_log();
    issue(8'h20, 8'h20, 8'h20, 4'd2, 1'b0);
    run_until_idle(200);
    chks("multi_order", log, "FDDDDDAFDDDDDAFDDDDDAP");
    chkn("multi_n_done", 32'(n_done), 32'd1);
    chkn("multi_done_at", 32'(done_cyc - start_cyc), 32'd47);
    chkn("multi_w0", 32'(act_w[0]), 32'h20);
    chkn("multi_i1", 32'(act_i[1]), 32'h30);
    chkn("multi_o2", 32'(act_o[2]), 32'h40);
    chkn("multi_w2", 32'(act_w[2]), 32'h40);
    chkn("multi_tile1", 32'(act_t[1]), 32'd1);
    chkn("multi_tile2", 32'(act_t[2]), 32'd2);
    chkn("multi_excl", 32'(excl), 32'd0);

    // Weight reuse applies to tile 0 only
    clear_log();
    issue(8'h10, 8'h20, 8'h30, 4'd1, 1'b1);
    run_until_idle(200);
    chks("reuse_order", log, "AFDDDDDAP");
    chkn("reuse_done_at", 32'(done_cyc - start_cyc), 32'd21);
    chkn("reuse_w1", 32'(act_w[1]), 32'h20);
    chkn("reuse_tile1", 32'(act_t[1]), 32'd1);

    // Timeout in COMPUTE_WAIT
    clear_log();
    out_en = 1'b0;
    issue(8'h00, 8'h00, 8'h00, 4'd0, 1'b0);
    for (int k = 0; k < 60 && !err; k++) step();
    chkn("to_err_set", 32'(err), 32'd1);
    chkn("to_err_at", 32'(cyc - start_cyc), 32'd27);
    chkn("to_strobes", 32'({fill_fifo, drain_fifo, active}), 32'd0);
    chkn("to_busy_done", 32'({busy, done}), 32'b10);
    step();
    chkn("to_back_idle", 32'({cmd_ready, busy, err}), 32'b101);
    chkn("to_no_done", 32'(n_done), 32'd0);
    out_en = 1'b1;
    clear_log();
    issue(8'h00, 8'h00, 8'h00, 4'd0, 1'b0);
    chkn("to_err_cleared", 32'(err), 32'd0);
    run_until_idle(100);
    chkn("to_recover_done", 32'(n_done), 32'd1);

    // Reset mid-DRAIN, then the same wrapping command reissued
    clear_log();
    issue(8'hF8, 8'h00, 8'h10, 4'd1, 1'b0);
    for (int k = 0; k < 20 && !drain_fifo; k++) step();
    step();
    chkn("rd_in_drain", 32'(drain_fifo), 32'd1);
    reset = 1'b0;
    #1;
    chkn("rd_drain_dropped", 32'(drain_fifo), 32'd0);
    chkn("rd_idle", 32'({cmd_ready, busy}), 32'b10);
    chkv("rd_w_cleared", w_bus, '0);
    mem_to_fifo_done = 1'b0;
    fifo_to_arr_done = 1'b0;
    output_done      = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    clear_log();
    @(negedge clk);
    issue(8'hF8, 8'h00, 8'h10, 4'd1, 1'b0);
    run_until_idle(200);
    chks("wrap_order", log, "FDDDDDAFDDDDDAP");
    chkn("wrap_w0", 32'(act_w[0]), 32'hF8);
    chkn("wrap_w1", 32'(act_w[1]), 32'h08);
    chkn("wrap_i1", 32'(act_i[1]), 32'h10);
    chkn("wrap_o1", 32'(act_o[1]), 32'h20);

    // Command offered while busy is dropped
    clear_log();
    issue(8'h55, 8'h66, 8'h77, 4'd0, 1'b0);
    for (int k = 0; k < 20 && !active; k++) step();
    step();
    chkn("busy_not_ready", 32'(cmd_ready), 32'd0);
    cmd_weight_base = 8'h99;
    cmd_input_base  = 8'hAA;
    cmd_output_base = 8'hBB;
    cmd_valid       = 1'b1;
    step();
    cmd_valid = 1'b0;
    chkv("busy_w_held", w_bus, rep8(8'h55));
    chkv("busy_i_held", i_bus, rep8(8'h66));
    chkv("busy_o_held", o_bus, rep8(8'h77));
    run_until_idle(100);
    repeat (3) step();
    chks("busy_order", log, "FDDDDDAP");
    chkn("busy_stays_idle", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
